// File: rtl/toy_bus_arb_node_dmem_req.sv
// 2:1 round-robin merge of dmem requests into one registered output; 1-cycle forward latency.
// Backpressure: an input is only ready when it holds the grant and the output slot is free or draining.
module toy_bus_arb_node_dmem_req #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int ID_W   = 4,
    parameter int SB_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic [ADDR_W-1:0] in0_strb,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_opcode,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    input  logic [SB_W-1:0]   in0_sideband,

    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic [ADDR_W-1:0] in1_strb,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_opcode,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,
    input  logic [SB_W-1:0]   in1_sideband,

    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic [ADDR_W-1:0] out0_addr,
    output logic [ADDR_W-1:0] out0_strb,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_opcode,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id,
    output logic [SB_W-1:0]   out0_sideband
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] strb;
        logic [DATA_W-1:0] data;
        logic              opcode;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
        logic [SB_W-1:0]   sideband;
    } req_t;

    req_t in0_req;
    req_t in1_req;
    req_t out_q;
    req_t out_d;
    logic out_vld_q;
    logic out_vld_d;
    logic last_gnt_q;
    logic last_gnt_d;
    logic gnt_sel;
    logic any_vld;
    logic slot_free;
    logic acc;

    assign in0_req = '{addr: in0_addr, strb: in0_strb, data: in0_data, opcode: in0_opcode,
                       src_id: in0_src_id, tgt_id: in0_tgt_id, sideband: in0_sideband};
    assign in1_req = '{addr: in1_addr, strb: in1_strb, data: in1_data, opcode: in1_opcode,
                       src_id: in1_src_id, tgt_id: in1_tgt_id, sideband: in1_sideband};

    // gnt_sel is only meaningful when any_vld; with no request it settles to 0.
    always_comb begin
        any_vld = in0_vld || in1_vld;
        if (in0_vld && in1_vld) begin
            gnt_sel = ~last_gnt_q;
        end else begin
            gnt_sel = in1_vld;
        end
        slot_free = !out_vld_q || out0_rdy;
        acc       = slot_free && any_vld;
    end

    // Ready is masked during reset so no request is acknowledged while the node is held.
    assign in0_rdy = rst_n && slot_free && any_vld && !gnt_sel;
    assign in1_rdy = rst_n && slot_free && gnt_sel;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        last_gnt_d = last_gnt_q;
        if (acc) begin
            out_vld_d  = 1'b1;
            out_d      = gnt_sel ? in1_req : in0_req;
            last_gnt_d = gnt_sel;
        end else if (out_vld_q && out0_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            last_gnt_q <= 1'b1;
        end else begin
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign out0_vld      = out_vld_q;
    assign out0_addr     = out_q.addr;
    assign out0_strb     = out_q.strb;
    assign out0_data     = out_q.data;
    assign out0_opcode   = out_q.opcode;
    assign out0_src_id   = out_q.src_id;
    assign out0_tgt_id   = out_q.tgt_id;
    assign out0_sideband = out_q.sideband;

endmodule

// File: tb/tb_toy_bus_arb_node_dmem_req.sv
// Bench for the dmem 2:1 request merge node: scoreboard of expected output order plus per-scenario checks.
module tb_toy_bus_arb_node_dmem_req;

    typedef struct packed {
        logic [31:0]  addr;
        logic [31:0]  strb;
        logic [255:0] data;
        logic         opcode;
        logic [3:0]   src_id;
        logic [3:0]   tgt_id;
        logic [9:0]   sideband;
    } pkt_t;

    logic         clk;
    logic         rst_n;
    logic         in0_vld, in0_rdy, in1_vld, in1_rdy;
    logic [31:0]  in0_addr, in0_strb, in1_addr, in1_strb;
    logic [255:0] in0_data, in1_data;
    logic         in0_opcode, in1_opcode;
    logic [3:0]   in0_src_id, in0_tgt_id, in1_src_id, in1_tgt_id;
    logic [9:0]   in0_sideband, in1_sideband;
    logic         out0_vld, out0_rdy;
    logic [31:0]  out0_addr, out0_strb;
    logic [255:0] out0_data;
    logic         out0_opcode;
    logic [3:0]   out0_src_id, out0_tgt_id;
    logic [9:0]   out0_sideband;
    pkt_t         out_pkt;

    int   n_checks = 0;
    int   n_fail   = 0;
    pkt_t s0[$];
    pkt_t s1[$];
    pkt_t sb[$];

    toy_bus_arb_node_dmem_req dut (
        .clk(clk), .rst_n(rst_n),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_strb(in0_strb),
        .in0_data(in0_data), .in0_opcode(in0_opcode), .in0_src_id(in0_src_id),
        .in0_tgt_id(in0_tgt_id), .in0_sideband(in0_sideband),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_strb(in1_strb),
        .in1_data(in1_data), .in1_opcode(in1_opcode), .in1_src_id(in1_src_id),
        .in1_tgt_id(in1_tgt_id), .in1_sideband(in1_sideband),
        .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_addr(out0_addr), .out0_strb(out0_strb),
        .out0_data(out0_data), .out0_opcode(out0_opcode), .out0_src_id(out0_src_id),
        .out0_tgt_id(out0_tgt_id), .out0_sideband(out0_sideband)
    );

    assign out_pkt = {out0_addr, out0_strb, out0_data, out0_opcode, out0_src_id, out0_tgt_id, out0_sideband};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output side of the scoreboard: every output handshake must match the next expected packet.
    always @(negedge clk) begin
        if (rst_n && out0_vld && out0_rdy) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got src=%0d addr=%h, required no output", out0_src_id, out0_addr);
            end else begin
                if (out_pkt !== sb[0]) begin
                    n_fail++;
                    $display("FAIL sb_payload: got src=%0d addr=%h tgt=%0d, required src=%0d addr=%h tgt=%0d",
                             out0_src_id, out0_addr, out0_tgt_id, sb[0].src_id, sb[0].addr, sb[0].tgt_id);
                end
                sb.delete(0);
            end
        end
    end

    function automatic pkt_t mk(input logic [3:0] src, input logic [31:0] addr, input logic [3:0] tgt);
        pkt_t p;
        p.addr     = addr;
        p.strb     = addr ^ 32'h0F0F_0F0F;
        p.data     = {8{addr ^ {4{src, tgt}}}};
        p.opcode   = addr[4];
        p.src_id   = src;
        p.tgt_id   = tgt;
        p.sideband = addr[9:0] ^ 10'h155;
        return p;
    endfunction

    task automatic apply_drive();
        in0_vld = (s0.size() != 0);
        in1_vld = (s1.size() != 0);
        if (in0_vld) {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband} = s0[0];
        if (in1_vld) {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband} = s1[0];
    endtask

    // One clock: sample handshakes on the falling edge, retire them and re-drive just after the rising edge.
    task automatic step(output logic hs0, output logic hs1);
        @(negedge clk);
        hs0 = in0_vld && in0_rdy;
        hs1 = in1_vld && in1_rdy;
        @(posedge clk);
        #1;
        if (hs0) s0.delete(0);
        if (hs1) s1.delete(0);
        apply_drive();
    endtask

    task automatic run_until_empty(input string name);
        logic h0, h1;
        int   cyc = 0;
        while ((s0.size() != 0 || s1.size() != 0) && cyc < 30) begin
            step(h0, h1);
            cyc++;
        end
        n_checks++;
        if (s0.size() != 0 || s1.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d/%0d pending inputs, required 0", name, s0.size(), s1.size());
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d outstanding packets, required 0", name, sb.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        s0.delete();
        s1.delete();
        sb.delete();
        apply_drive();
        out0_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        out0_rdy = 1'b1;
        s0.push_back(mk(4'd1, 32'h0000_0040, 4'd2));
        apply_drive();
        repeat (3) @(negedge clk);
        n_checks++;
        if (out0_vld !== 1'b0 || out_pkt !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got vld=%b addr=%h, required vld=0 payload=0", out0_vld, out0_addr);
        end
        n_checks++;
        if (in0_rdy !== 1'b0 || in1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy: got in0_rdy=%b in1_rdy=%b, required 0 0", in0_rdy, in1_rdy);
        end
        s0.delete();
        apply_drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic h0, h1;
        pkt_t p;
        p = mk(4'd1, 32'h0000_1000, 4'd3);
        out0_rdy = 1'b1;
        s0.push_back(p);
        sb.push_back(p);
        apply_drive();
        step(h0, h1);
        n_checks++;
        if (h0 !== 1'b1 || h1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rdy: got hs0=%b hs1=%b, required 1 0", h0, h1);
        end
        n_checks++;
        if (out0_vld !== 1'b1 || out0_addr !== 32'h0000_1000 || out0_tgt_id !== 4'd3) begin
            n_fail++;
            $display("FAIL single_latency: got vld=%b addr=%h tgt=%0d, required 1 00001000 3", out0_vld, out0_addr, out0_tgt_id);
        end
        step(h0, h1);
        n_checks++;
        if (out0_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: got vld=%b, required 0", out0_vld);
        end
        wait_drain("single");
    endtask

    task automatic test_fairness();
        logic h0, h1;
        int   cyc = 0;
        apply_reset();
        out0_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0.push_back(mk(4'd1, 32'h0000_2000 + 32'(i * 16), 4'd5));
            s1.push_back(mk(4'd2, 32'h0000_3000 + 32'(i * 16), 4'd6));
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back(s0[i]);
            sb.push_back(s1[i]);
        end
        apply_drive();
        while ((s0.size() != 0 || s1.size() != 0) && cyc < 20) begin
            step(h0, h1);
            cyc++;
            n_checks++;
            if ((h0 ^ h1) !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_one_per_cycle: got hs0=%b hs1=%b in cycle %0d, required exactly one", h0, h1, cyc);
            end
        end
        n_checks++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL fair_throughput: got %0d cycles, required 8", cyc);
        end
        wait_drain("fair");
    endtask

    task automatic test_stall();
        logic h0, h1;
        pkt_t a0;
        a0 = mk(4'd1, 32'h0000_4000, 4'd7);
        out0_rdy = 1'b0;
        s0.push_back(a0);
        s0.push_back(mk(4'd1, 32'h0000_4010, 4'd7));
        s1.push_back(mk(4'd2, 32'h0000_5000, 4'd8));
        s1.push_back(mk(4'd2, 32'h0000_5010, 4'd8));
        sb.push_back(s0[0]);
        sb.push_back(s1[0]);
        sb.push_back(s0[1]);
        sb.push_back(s1[1]);
        apply_drive();
        step(h0, h1);
        n_checks++;
        if (h0 !== 1'b1 || h1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_first_grant: got hs0=%b hs1=%b, required 1 0", h0, h1);
        end
        for (int i = 0; i < 5; i++) begin
            step(h0, h1);
            n_checks++;
            if (h0 !== 1'b0 || h1 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_rdy: got hs0=%b hs1=%b in stall cycle %0d, required 0 0", h0, h1, i);
            end
            n_checks++;
            if (out0_vld !== 1'b1 || out_pkt !== a0) begin
                n_fail++;
                $display("FAIL stall_hold: got vld=%b addr=%h in stall cycle %0d, required 1 %h", out0_vld, out0_addr, i, a0.addr);
            end
        end
        out0_rdy = 1'b1;
        step(h0, h1);
        n_checks++;
        if (h0 !== 1'b0 || h1 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_grant: got hs0=%b hs1=%b, required 0 1", h0, h1);
        end
        run_until_empty("stall");
        wait_drain("stall");
    endtask

    task automatic test_stream_in1();
        logic h0, h1;
        pkt_t p;
        pkt_t last;
        out0_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = mk(4'd2, 32'h0000_6000 + 32'(i * 4), 4'd9);
            p.data = {32{8'hA5}};
            p.strb = 32'hFFFF_FFFF;
            s1.push_back(p);
        end
        last = s1[5];
        for (int i = 0; i < 3; i++) sb.push_back(s1[i]);
        p = mk(4'd1, 32'h0000_7000, 4'd4);
        sb.push_back(p);
        for (int i = 3; i < 6; i++) sb.push_back(s1[i]);
        apply_drive();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                s0.push_back(p);
                apply_drive();
            end
            step(h0, h1);
            n_checks++;
            if (h0 !== (i == 3) || h1 !== (i != 3)) begin
                n_fail++;
                $display("FAIL stream_grant: got hs0=%b hs1=%b in cycle %0d, required %b %b", h0, h1, i, i == 3, i != 3);
            end
        end
        // Drain only: last packet leaves, nothing new arrives.
        n_checks++;
        if (out0_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_pre: got vld=%b, required 1", out0_vld);
        end
        step(h0, h1);
        n_checks++;
        if (out0_vld !== 1'b0 || out_pkt !== last) begin
            n_fail++;
            $display("FAIL drain_only: got vld=%b addr=%h, required 0 with payload %h held", out0_vld, out0_addr, last.addr);
        end
        wait_drain("stream");
        s0.push_back(mk(4'd1, 32'h0000_7100, 4'd1));
        s1.push_back(mk(4'd2, 32'h0000_7200, 4'd2));
        sb.push_back(s0[0]);
        sb.push_back(s1[0]);
        apply_drive();
        run_until_empty("drain_ptr");
        wait_drain("drain_ptr");
    endtask

    task automatic test_reset_mid();
        logic h0, h1;
        out0_rdy = 1'b0;
        s0.push_back(mk(4'd1, 32'h0000_8000, 4'd3));
        s0.push_back(mk(4'd1, 32'h0000_8010, 4'd3));
        apply_drive();
        step(h0, h1);
        n_checks++;
        if (out0_vld !== 1'b1 || h0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_load: got vld=%b hs0=%b, required 1 1", out0_vld, h0);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out0_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got vld=%b, required 0", out0_vld);
        end
        n_checks++;
        if (in0_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_rdy: got in0_rdy=%b, required 0", in0_rdy);
        end
        s0.delete();
        apply_drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out0_rdy = 1'b1;
        s0.push_back(mk(4'd1, 32'h0000_9000, 4'd5));
        s1.push_back(mk(4'd2, 32'h0000_9100, 4'd6));
        sb.push_back(s0[0]);
        sb.push_back(s1[0]);
        apply_drive();
        step(h0, h1);
        n_checks++;
        if (h0 !== 1'b1 || h1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ptr: got hs0=%b hs1=%b, required 1 0", h0, h1);
        end
        run_until_empty("rstmid");
        wait_drain("rstmid");
    endtask

    initial begin
        in0_vld = 1'b0; in0_addr = '0; in0_strb = '0; in0_data = '0; in0_opcode = 1'b0;
        in0_src_id = '0; in0_tgt_id = '0; in0_sideband = '0;
        in1_vld = 1'b0; in1_addr = '0; in1_strb = '0; in1_data = '0; in1_opcode = 1'b0;
        in1_src_id = '0; in1_tgt_id = '0; in1_sideband = '0;
        out0_rdy = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_stream_in1();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/toy_bus_arb_node_dmem_req.md
Name: toy_bus_arb_node_dmem_req

Overview:
- 2:1 request merge node sitting directly downstream of the dmem request decoder (`toy_bus_DDec_node_dec_dmem_*`) outputs.
- Collects ToyBusReq packets from two decoder branches and applies round-robin arbitration.
- Drives one registered output channel toward the dmem target port.
- Supports full throughput (1 packet/cycle) with a 1-cycle forward latency.

Parameters:
- ADDR_W, 32, address/strobe width
- DATA_W, 256, data width
- ID_W, 4, src_id/tgt_id width
- SB_W, 10, sideband width

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- in0_vld, in1_vld  input  1  request valid per input
- in0_rdy, in1_rdy  output  1  request ready per input
- in0_addr, in1_addr  input  ADDR_W  address
- in0_strb, in1_strb  input  ADDR_W  byte strobe
- in0_data, in1_data  input  DATA_W  write data
- in0_opcode, in1_opcode  input  1  opcode (1 = write)
- in0_src_id, in1_src_id  input  ID_W  source id
- in0_tgt_id, in1_tgt_id  input  ID_W  target id
- in0_sideband, in1_sideband  input  SB_W  sideband
- out0_vld  output  1  registered valid
- out0_rdy  input  1  downstream ready
- out0_addr/strb/data/opcode/src_id/tgt_id/sideband  output  same widths as inputs  registered payload

Behaviour:
- Reset (rst_n low, asynchronous):
  - out0_vld=0; all out0 payload registers=0; rr pointer last_gnt=1, so in0 wins the first conflict.
  - in0_rdy/in1_rdy=0 while reset is asserted.
- Slot free: `slot_free = !out0_vld || out0_rdy`.
- Grant (combinational, evaluated every cycle):
  - Only in0_vld: gnt=in0. Only in1_vld: gnt=in1.
  - Both valid: gnt = the input that is not last_gnt.
  - Neither valid: no grant.
- Ready: `inK_rdy = slot_free && gnt==K`.
  - Ready never depends on the other input's ready.
  - A non-granted input sees rdy=0.
- Accept: `acc = slot_free && (in0_vld || in1_vld)`. On acc:
  - Output registers load the granted payload.
  - out0_vld <= 1.
  - last_gnt <= gnt.
- Drain only: if `out0_vld && out0_rdy && !acc`, then out0_vld <= 0; payload registers hold their value.
- Stall (`out0_vld && !out0_rdy`):
  - out0_vld and payload are held stable.
  - last_gnt is unchanged.
- Pointer rule: last_gnt updates only on an accepted handshake, never on valid alone. This keeps the grant stable while the output stalls.
- Latency: 1 cycle from input handshake to out0_vld. Back-to-back accepts run every cycle while out0_rdy=1.
- Fairness: with both inputs continuously valid, grants alternate 0,1,0,1,... No input waits more than 1 accepted packet.
- Payload pass-through: every field is copied unmodified (no tgt_id rewrite) and no field-width conversion is done.
- Upstream valid rules:
  - Upstream may not drop vld before its handshake; behaviour on violation is unspecified.
  - inK_vld may rise in any cycle.
- Reset mid-operation:
  - A packet held in the output register is discarded; out0_vld drops immediately and asynchronously.
  - In-flight input requests are not acknowledged.

Test Plan:
- Reset, then in0_vld=1 with addr=0x1000, tgt_id=3, out0_rdy=1 -> in0_rdy=1 in cycle 0; out0_vld=1 with addr=0x1000, tgt_id=3 in cycle 1, then 0 in cycle 2.
- in0 and in1 both valid for 4 packets each, out0_rdy=1 -> out0 order is in0,in1,in0,in1,... (src_id 1,2,1,2 when sources use 1/2); 8 packets in 8 consecutive cycles.
- Output stall: out0_vld=1, out0_rdy=0 for 5 cycles with both inputs valid -> payload stable and in0_rdy=in1_rdy=0 for all 5 cycles; the winner after release is the one not granted last.
- Single source in1 streaming (data=0xA5 pattern, strb=0xFFFFFFFF), in0 idle -> in1 granted every cycle and full throughput; a new in0 request is granted on the next accept.
- Drain only: out0_vld=1, out0_rdy=1, no inputs valid -> out0_vld=0 next cycle; pointer unchanged.
- Assert rst_n=0 mid-stream with out0_vld=1 -> out0_vld=0 asynchronously. After release, the first conflict grants in0.
